// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared constants and entry type for the fetch stage
package fetch_queue_pkg;

    localparam int          IM_AWIDTH        = 10;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - generic synchronous FIFO with clear, occupancy count and registered storage
module fetch_fifo #(
    parameter int  WIDTH = 64,
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt_q == (AW + 1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt_q  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign count = cnt_q;

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch PC, prefetch buffer arbitration and decode-side outputs
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    localparam int         CW       = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [IM_AWIDTH-1:0] im_addr,
    input  logic [31:0]          im_dout,
    input  logic                 redirect,
    input  logic [31:0]          redirect_pc,
    input  logic                 stall,
    output logic                 out_valid,
    output logic [31:0]          out_pc,
    output logic [31:0]          out_instr,
    output logic [CW-1:0]        count
);

    logic [31:0]  fetch_pc;
    logic         push;
    logic         pop;
    logic         full;
    logic         empty;
    fetch_entry_t wr_entry;
    fetch_entry_t head;

    assign im_addr   = fetch_pc[IM_AWIDTH+1:2];
    assign out_valid = ~empty;

    // Redirect overrides everything: no consume, no fill, buffer cleared.
    assign pop  = out_valid & ~stall & ~redirect;
    assign push = ~redirect & (~full | pop);

    assign wr_entry.pc    = fetch_pc;
    assign wr_entry.instr = im_dout;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
        end else if (redirect) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
        end else if (push) begin
            fetch_pc <= fetch_pc + 32'd4;
        end
    end

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (redirect),
        .push  (push),
        .pop   (pop),
        .din   (wr_entry),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // Stale storage is never exposed; an empty buffer presents a nop at PC 0.
    assign out_pc    = out_valid ? head.pc    : 32'd0;
    assign out_instr = out_valid ? head.instr : 32'd0;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed and randomized checks of fetch_queue against a queue-based model
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  im_addr;
    logic [31:0] im_dout;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [2:0]  count;

    int unsigned pass_n  = 0;
    int unsigned total_n = 0;

    ent_t        q[$];
    logic [31:0] mpc;

    fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .im_addr     (im_addr),
        .im_dout     (im_dout),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .out_valid   (out_valid),
        .out_pc      (out_pc),
        .out_instr   (out_instr),
        .count       (count)
    );

    always #5 clk = ~clk;

    // Instruction memory: word k holds 0x1000_0000 + k, aliased every 4 KB.
    assign im_dout = 32'h1000_0000 + {22'd0, im_addr};

    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        return 32'h1000_0000 + {22'd0, pc[11:2]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_n++;
        assert (obs === exp) pass_n++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        q.delete();
        mpc = RESET_PC;
    endtask

    task automatic model_edge();
        bit v;
        bit p_pop;
        bit p_push;
        if (!rst) begin
            model_reset();
        end else if (redirect) begin
            q.delete();
            mpc = {redirect_pc[31:2], 2'b00};
        end else begin
            v      = (q.size() > 0);
            p_pop  = v && !stall;
            p_push = (q.size() < DEPTH) || p_pop;
            if (p_pop) void'(q.pop_front());
            if (p_push) begin
                q.push_back('{pc: mpc, instr: mem_word(mpc)});
                mpc = mpc + 32'd4;
            end
        end
    endtask

    task automatic check_model();
        logic        ev;
        logic [31:0] epc;
        logic [31:0] ein;
        ev  = (q.size() > 0);
        epc = ev ? q[0].pc : 32'd0;
        ein = ev ? q[0].instr : 32'd0;
        chk("model_valid", 64'(out_valid), 64'(ev));
        chk("model_pc", 64'(out_pc), 64'(epc));
        chk("model_instr", 64'(out_instr), 64'(ein));
        chk("model_count", 64'(count), 64'(q.size()));
        chk("model_im_addr", 64'(im_addr), 64'(mpc[11:2]));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model();
    endtask

    initial begin
        rst         = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_valid", 64'(out_valid), 64'd0);
        chk("reset_pc", 64'(out_pc), 64'd0);
        chk("reset_instr", 64'(out_instr), 64'd0);
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_im_addr", 64'(im_addr), 64'(RESET_PC[11:2]));

        rst = 1'b1;
        #1;
        chk("pre_fetch_valid", 64'(out_valid), 64'd0);
        cycle();
        chk("first_valid", 64'(out_valid), 64'd1);
        chk("first_pc", 64'(out_pc), 64'(RESET_PC));

        for (int i = 1; i < 6; i++) begin
            cycle();
            chk("seq_pc", 64'(out_pc), 64'(32'(4 * i)));
            chk("seq_instr", 64'(out_instr), 64'(32'h1000_0000 + 32'(i)));
            chk("seq_count", 64'(count), 64'd1);
        end

        stall = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("stall_hold_pc", 64'(out_pc), 64'h14);
        end
        chk("stall_full_count", 64'(count), 64'd4);
        chk("stall_im_addr", 64'(im_addr), 64'd9);

        stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("release_pc", 64'(out_pc), 64'(32'h18 + 32'(4 * i)));
        end

        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        cycle();
        redirect = 1'b0;
        chk("wrap_bubble", 64'(out_valid), 64'd0);
        chk("wrap_im_addr0", 64'(im_addr), 64'h3FF);
        cycle();
        chk("wrap_pc0", 64'(out_pc), 64'hFFFF_FFFC);
        chk("wrap_im_addr1", 64'(im_addr), 64'h000);
        cycle();
        chk("wrap_pc1", 64'(out_pc), 64'h0);

        stall = 1'b1;
        repeat (2) cycle();
        chk("three_count", 64'(count), 64'd3);
        stall       = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        cycle();
        redirect = 1'b0;
        chk("redir_valid", 64'(out_valid), 64'd0);
        chk("redir_count", 64'(count), 64'd0);
        chk("redir_im_addr", 64'(im_addr), 64'h040);
        cycle();
        chk("redir_target_pc", 64'(out_pc), 64'h100);
        chk("redir_target_instr", 64'(out_instr), 64'h1000_0040);

        stall = 1'b1;
        repeat (4) cycle();
        chk("full_before_redir", 64'(count), 64'd4);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        cycle();
        redirect = 1'b0;
        chk("redir_stall_empty", 64'(count), 64'd0);
        chk("redir_stall_valid", 64'(out_valid), 64'd0);
        cycle();
        chk("redir_stall_target", 64'(out_pc), 64'h200);
        chk("redir_stall_tvalid", 64'(out_valid), 64'd1);
        stall = 1'b0;

        for (int i = 0; i < 400; i++) begin
            stall       = ($urandom_range(0, 9) < 4);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = $urandom;
            cycle();
        end

        stall       = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0300;
        cycle();
        redirect = 1'b0;
        stall    = 1'b1;
        repeat (3) cycle();
        chk("pre_reset_count", 64'(count), 64'd3);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("async_valid", 64'(out_valid), 64'd0);
        chk("async_count", 64'(count), 64'd0);
        chk("async_im_addr", 64'(im_addr), 64'(RESET_PC[11:2]));
        repeat (2) begin
            cycle();
            chk("held_reset_valid", 64'(out_valid), 64'd0);
        end
        rst   = 1'b1;
        stall = 1'b0;
        cycle();
        chk("rerelease_pc", 64'(out_pc), 64'(RESET_PC));
        chk("rerelease_valid", 64'(out_valid), 64'd1);

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule
